// File: rtl/regwrite_queue_if.sv
// Bundle of producer handshake, register-file drain port and forwarding lookups
// for the register write queue.
//
// Handshake: a write moves from producer to queue exactly when inValid and
// inReady are both high at a rising clock edge; inReady never depends on
// inValid, and the producer holds inRegister/inData stable while inValid is high.
interface regwrite_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                     inValid;
  logic                     inReady;
  logic [ADDR_W-1:0]        inRegister;
  logic [DATA_W-1:0]        inData;
  logic                     drainEnable;
  logic                     regWrite;
  logic [ADDR_W-1:0]        writeRegister;
  logic [DATA_W-1:0]        writeData;
  logic [ADDR_W-1:0]        readRegister1;
  logic [ADDR_W-1:0]        readRegister2;
  logic                     fwdHit1;
  logic                     fwdHit2;
  logic [DATA_W-1:0]        fwdData1;
  logic [DATA_W-1:0]        fwdData2;
  logic [$clog2(DEPTH):0]   count;

  // Producer / register-file side of the queue.
  modport master (
    output inValid, inRegister, inData, drainEnable, readRegister1, readRegister2,
    input  inReady, regWrite, writeRegister, writeData,
           fwdHit1, fwdHit2, fwdData1, fwdData2, count
  );

  // The queue itself.
  modport slave (
    input  inValid, inRegister, inData, drainEnable, readRegister1, readRegister2,
    output inReady, regWrite, writeRegister, writeData,
           fwdHit1, fwdHit2, fwdData1, fwdData2, count
  );
endinterface

// File: rtl/regwrite_queue.sv
// Register write queue: buffers writeback results in a circular FIFO, issues at
// most one register-file write per cycle, drops writes to r0 and forwards the
// youngest queued value for each read lookup.
module regwrite_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input logic              clock,
  input logic              reset,
  regwrite_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] entryAddr [DEPTH];
  logic [DATA_W-1:0] entryData [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  countReg;

  logic notFull;
  logic notEmpty;
  logic pushStore;
  logic popHead;

  // Full queue never accepts, even when it drains on the same edge; r0 writes
  // complete the handshake but are never stored.
  always_comb begin
    notFull   = (countReg != CNT_W'(DEPTH));
    notEmpty  = (countReg != '0);
    pushStore = bus.inValid && notFull && (bus.inRegister != '0);
    popHead   = notEmpty && bus.drainEnable;
  end

  assign bus.inReady  = notFull;
  assign bus.regWrite = popHead;
  assign bus.count    = countReg;

  // Drain port shows the head entry whenever the queue holds anything.
  always_comb begin
    bus.writeRegister = '0;
    bus.writeData     = '0;
    if (notEmpty) begin
      bus.writeRegister = entryAddr[headPtr];
      bus.writeData     = entryData[headPtr];
    end
  end

  // Pointer and occupancy update; reset wins over any same-edge push or pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      countReg <= '0;
    end else begin
      if (pushStore) tailPtr <= tailPtr + 1'b1;
      if (popHead)   headPtr <= headPtr + 1'b1;
      countReg <= countReg + CNT_W'(pushStore) - CNT_W'(popHead);
    end
  end

  // Entry storage; contents beyond count are don't-care so no reset is needed.
  always_ff @(posedge clock) begin
    if (!reset && pushStore) begin
      entryAddr[tailPtr] <= bus.inRegister;
      entryData[tailPtr] <= bus.inData;
    end
  end

  // Forwarding: walk entries oldest to youngest so the youngest match is kept.
  // The head being drained this cycle still counts; the offered input does not.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot         = '0;
    bus.fwdHit1  = 1'b0;
    bus.fwdHit2  = 1'b0;
    bus.fwdData1 = '0;
    bus.fwdData2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = headPtr + PTR_W'(k);
      if (CNT_W'(k) < countReg) begin
        if (bus.readRegister1 != '0 && entryAddr[slot] == bus.readRegister1) begin
          bus.fwdHit1  = 1'b1;
          bus.fwdData1 = entryData[slot];
        end
        if (bus.readRegister2 != '0 && entryAddr[slot] == bus.readRegister2) begin
          bus.fwdHit2  = 1'b1;
          bus.fwdData2 = entryData[slot];
        end
      end
    end
  end
endmodule

// File: tb/tb_regwrite_queue.sv
// Bench for regwrite_queue: directed offers push expected register-file writes
// into a queue, and an independent monitor pops and compares on every regWrite.
module tb_regwrite_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  regwrite_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regwrite_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every register-file write must match the oldest expected entry
  initial begin
    forever begin
      @(negedge clock);
      if (bus.regWrite === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write",
                   bus.writeRegister, bus.writeData);
        end else begin
          check("drain_write", {bus.writeRegister, bus.writeData}, exp_q.pop_front());
        end
      end
    end
  end

  // driver: offer one write for one cycle; the bench decides acceptance itself
  task automatic offer(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                       input logic expAccept);
    bus.inValid    = 1'b1;
    bus.inRegister = r;
    bus.inData     = d;
    @(negedge clock);
    check("in_ready", bus.inReady, expAccept);
    if (expAccept && r != '0) exp_q.push_back({r, d});
    @(posedge clock);
    #1;
    bus.inValid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.inValid = 1'b0;
    bus.inRegister = '0;
    bus.inData = '0;
    bus.drainEnable = 1'b0;
    bus.readRegister1 = 4'd3;
    bus.readRegister2 = 4'd5;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    @(negedge clock);
    check("rst_count", bus.count, 0);
    check("rst_in_ready", bus.inReady, 1);
    check("rst_reg_write", bus.regWrite, 0);
    check("rst_write_register", bus.writeRegister, 0);
    check("rst_write_data", bus.writeData, 0);
    check("rst_fwd_hit1", bus.fwdHit1, 0);
    check("rst_fwd_hit2", bus.fwdHit2, 0);
    check("rst_fwd_data1", bus.fwdData1, 0);
    @(posedge clock); #1;

    // fill with draining held off
    offer(4'd3, 32'h11, 1);
    offer(4'd5, 32'h22, 1);
    offer(4'd3, 32'h33, 1);
    offer(4'd7, 32'h44, 1);
    @(negedge clock);
    check("full_count", bus.count, 4);
    check("full_fwd_hit1", bus.fwdHit1, 1);
    check("full_fwd_data1_youngest", bus.fwdData1, 32'h33);
    check("full_fwd_data2", bus.fwdData2, 32'h22);
    check("held_write_register", bus.writeRegister, 3);
    @(posedge clock); #1;
    offer(4'd9, 32'h55, 0);
    @(negedge clock);
    check("full_no_accept_count", bus.count, 4);
    @(posedge clock); #1;

    // drain the full queue: four consecutive writes, checked by the monitor
    bus.drainEnable = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("drain_consecutive", bus.regWrite, 1);
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("drained_count", bus.count, 0);
    check("drained_reg_write", bus.regWrite, 0);
    check("drained_exp_q", exp_q.size(), 0);
    @(posedge clock); #1;

    // single-entry latency and forwarding drop after commit
    bus.readRegister1 = 4'd6;
    offer(4'd6, 32'h66, 1);
    @(negedge clock);
    check("latency_reg_write", bus.regWrite, 1);
    check("latency_fwd_hit", bus.fwdHit1, 1);
    check("latency_fwd_data", bus.fwdData1, 32'h66);
    @(posedge clock); #1;
    @(negedge clock);
    check("post_commit_fwd_hit", bus.fwdHit1, 0);
    @(posedge clock); #1;

    // write to r0 is swallowed
    bus.readRegister1 = 4'd0;
    offer(4'd0, 32'hDEAD, 1);
    @(negedge clock);
    check("r0_count", bus.count, 0);
    check("r0_fwd_hit", bus.fwdHit1, 0);
    check("r0_reg_write", bus.regWrite, 0);
    @(posedge clock); #1;

    // steady state at count 2 with simultaneous accept and drain, wrapping pointers
    bus.drainEnable = 1'b0;
    offer(4'd1, 32'h101, 1);
    offer(4'd2, 32'h102, 1);
    bus.drainEnable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.inValid    = 1'b1;
      bus.inRegister = ADDR_W'((i % 7) + 8);
      bus.inData     = 32'h200 + DATA_W'(i);
      @(negedge clock);
      check("steady_count", bus.count, 2);
      exp_q.push_back({bus.inRegister, bus.inData});
      @(posedge clock); #1;
    end
    bus.inValid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("steady_drained_count", bus.count, 0);
    check("steady_exp_q", exp_q.size(), 0);
    @(posedge clock); #1;

    // reset mid-operation together with an offer
    bus.drainEnable = 1'b0;
    offer(4'd4, 32'hA, 1);
    offer(4'd8, 32'hB, 1);
    offer(4'd9, 32'hC, 1);
    bus.readRegister1 = 4'd4;
    bus.readRegister2 = 4'd10;
    reset = 1'b1;
    bus.inValid = 1'b1;
    bus.inRegister = 4'd10;
    bus.inData = 32'hD;
    @(posedge clock); #1;
    reset = 1'b0;
    bus.inValid = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("reset_mid_count", bus.count, 0);
    check("reset_mid_reg_write", bus.regWrite, 0);
    check("reset_mid_fwd_hit1", bus.fwdHit1, 0);
    check("reset_mid_fwd_hit2", bus.fwdHit2, 0);
    @(posedge clock); #1;
    bus.drainEnable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_mid_still_empty", bus.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
